id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Parametrised ID->EX pipeline stage with valid/ready handshake, stall and flush.
//  Carries decoded control bits plus payload (rs1/rs2 values, immediate, instruction, reg addresses).
//  Flush turns the stage into a bubble with all control bits zeroed.
//  Sits between decode/hazard unit and the EX stage; it replaces the unconditional ID/EX latch.
// PARAMETERS
//  XLEN      32  width of register values, immediate and instruction
//  RA_W      5   register-address width (rs1, rs2, rd)
//  CTRL_W    7   control bundle width; field layout defined in pipe_pkg
//  CNT_W     16  width of the bubble-cycle counter
// PORTS
//  clk        in   1        stage clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        decode presents a valid instruction
//  in_ready   out  1        stage accepts in_* this cycle
//  in_ctrl    in   CTRL_W   {ALUOp[1:0],RegWrite,MemWrite,MemRead,MemtoReg,ALUSrc}
//  in_rs1_val in   XLEN     rs1 operand value
//  in_rs2_val in   XLEN     rs2 operand value
//  in_imm     in   XLEN     sign-extended immediate
//  in_instr   in   XLEN     raw instruction word
//  in_rs1     in   RA_W     rs1 address (forwarding unit)
//  in_rs2     in   RA_W     rs2 address
//  in_rd      in   RA_W     destination address
//  flush      in   1        kill stage contents (branch mispredict / hazard bubble)
//  out_valid  out  1        EX-side entry valid
//  out_ready  in   1        EX consumes entry; 0 = stall
//  out_ctrl, out_rs1_val, out_rs2_val, out_imm, out_instr, out_rs1, out_rs2, out_rd  out  as inputs
//  bubble_cnt out  CNT_W    cycles in which out_valid==0
// BEHAVIOUR
//  Reset: out_valid=0, every out_* field=0, bubble_cnt=0; in_ready=1 with skid, else follows rule below.
//  Accept: in_valid&&in_ready&&!flush. Release: out_valid&&out_ready.
//  Base (no skid): in_ready = !out_valid || out_ready (comb); latency 1 cycle in->out.
//   Accept loads all fields and sets out_valid; release without accept clears out_valid.
//  Stall (out_valid&&!out_ready): all out_* held bit-stable; no accept.
//  out_ctrl forced to 0 whenever out_valid==0 (bubble never asserts RegWrite/MemWrite/MemRead).
//  Data fields of a bubble hold last value (don't-care downstream, not cleared).
//  Flush: priority over accept/release; next cycle out_valid=0, skid emptied; in-flight input dropped.
//  bubble_cnt increments each cycle out_valid==0, saturates at all-ones; not cleared by flush.
//  Reset mid-operation clears valid/ctrl asynchronously; no partial transfer survives.
// CONFIGURATION
//  ID_EX_SKID_EN defined: 2-entry skid buffer, in_ready registered (= !skid_valid), breaks ready path.
//   States EMPTY(0), ONE(main valid), FULL(main+skid valid).
//   EMPTY-accept->ONE; ONE accept&release->ONE; ONE accept&!release->FULL (data into skid);
//   ONE release-only->EMPTY; FULL release->ONE (skid->main); FULL never accepts; flush->EMPTY.
//   Ordering strictly FIFO; latency 1 cycle when not stalled.
//  ID_EX_SKID_EN undefined: single register, combinational in_ready as in base rule.
// STRUCTURE
//  pipe_pkg: CTRL_W, field index localparams (CTRL_ALUSRC..CTRL_ALUOP), ctrl_t struct, ID_EX_CTRL_NOP.
//  One sub-module id_ex_slot: payload register with load enable and valid bit; instanced once
//   (main) or twice (main+skid) under ID_EX_SKID_EN.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> out_valid=0, out_ctrl=0, bubble_cnt=0 immediately, no clk needed.
//  2 Stream: in_valid=1 rd=1..8, out_ready=1 -> out_rd=1..8 one cycle later, no gaps, bubble_cnt frozen.
//  3 Stall: out_ready=0 for 3 cycles holding rd=5 -> out_* stable, in_ready low (base) or after 1 accept (skid).
//  4 Flush: flush=1 with ctrl=7'h1F valid -> next cycle out_valid=0, out_ctrl=0; subsequent rd=9 passes.
//  5 Skid: out_ready=0, send rd=3,4 -> FULL, in_ready=0; out_ready=1 -> out_rd 3 then 4, in order.
//  6 Counter: CNT_W=4, idle 20 cycles -> bubble_cnt saturates at 4'hF, no wrap.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for the ID->EX pipeline stage.
//   CTRL_W           width of the decoded control bundle
//   CTRL_* indices   bit position of each control field inside the bundle
//   ctrl_t           packed view of the control bundle (MSB first)
//   ID_EX_CTRL_NOP   control value carried by a bubble (nothing written)
//   skid_state_e     occupancy states of the optional skid buffer
package pipe_pkg;

  localparam int CTRL_W = 7;

  localparam int CTRL_ALUSRC   = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_REGWRITE = 4;
  localparam int CTRL_ALUOP    = 5;  // two bits: [6:5]

  typedef struct packed {
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       alu_src;
  } ctrl_t;

  localparam ctrl_t ID_EX_CTRL_NOP = '0;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,  // nothing held
    SKID_ONE   = 2'd1,  // main slot valid
    SKID_FULL  = 2'd2   // main and skid slots valid
  } skid_state_e;

endpackage

// File: rtl/id_ex_slot.sv
// id_ex_slot -- one payload register with load enable plus its valid bit.
//   clk      stage clock, rising edge
//   rst_n    asynchronous active-low reset (payload and valid cleared)
//   load     capture d on the next rising edge
//   d        payload input (W bits)
//   valid_d  next value of the valid bit
//   q        registered payload
//   valid_q  registered valid bit
module id_ex_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         valid_d,
  output logic [W-1:0] q,
  output logic         valid_q
);

  logic [W-1:0] data_q, data_d;
  logic         vld_q;

  always_comb begin
    data_d = data_q;
    if (load) data_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= valid_d;
    end
  end

  assign q       = data_q;
  assign valid_q = vld_q;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID->EX pipeline register with valid/ready handshake,
// stall, flush and a saturating bubble-cycle counter.
//   clk, rst_n                 clock / asynchronous active-low reset
//   in_valid, in_ready         decode-side handshake
//   in_ctrl .. in_rd           control bundle and payload from decode
//   flush                      drop stage contents and any input this cycle
//   out_valid, out_ready       EX-side handshake (out_ready=0 stalls)
//   out_ctrl .. out_rd         registered control/payload; out_ctrl is zero
//                              whenever out_valid is low
//   bubble_cnt                 cycles with out_valid low, saturating
// Build option: define ID_EX_SKID_EN for a two-entry skid buffer whose
// in_ready is a flop output (breaks the out_ready -> in_ready path).
// Without it a single register is used and in_ready is combinational.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [XLEN-1:0]   in_rs1_val,
  input  logic [XLEN-1:0]   in_rs2_val,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_instr,
  input  logic [RA_W-1:0]   in_rs1,
  input  logic [RA_W-1:0]   in_rs2,
  input  logic [RA_W-1:0]   in_rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [XLEN-1:0]   out_rs1_val,
  output logic [XLEN-1:0]   out_rs2_val,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_instr,
  output logic [RA_W-1:0]   out_rs1,
  output logic [RA_W-1:0]   out_rs2,
  output logic [RA_W-1:0]   out_rd,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int PW = CTRL_W + 4 * XLEN + 3 * RA_W;

  logic [PW-1:0]     in_pay;
  logic [PW-1:0]     main_q;
  logic              main_valid;
  logic              accept;
  logic              rel;
  logic [CTRL_W-1:0] ctrl_raw;

  assign in_pay = {in_ctrl, in_rs1_val, in_rs2_val, in_imm, in_instr,
                   in_rs1, in_rs2, in_rd};

`ifdef ID_EX_SKID_EN
  skid_state_e   state_q, state_d;
  logic          main_load, skid_load, skid_valid;
  logic [PW-1:0] main_d, skid_q;

  // The skid slot being occupied is the only thing that blocks input, so
  // its registered valid bit is in_ready directly.
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready && !flush;
  assign rel      = main_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = in_pay;
    if (flush) begin
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (accept) begin
            state_d   = SKID_ONE;
            main_load = 1'b1;
          end
        end
        SKID_ONE: begin
          if (accept && rel) begin
            main_load = 1'b1;
          end else if (accept) begin
            // EX stalled: park the new entry behind the main one
            state_d   = SKID_FULL;
            skid_load = 1'b1;
          end else if (rel) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (rel) begin
            state_d   = SKID_ONE;
            main_load = 1'b1;
            main_d    = skid_q;  // older entry advances, FIFO order kept
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SKID_EMPTY;
    else        state_q <= state_d;
  end

  id_ex_slot #(.W(PW)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (main_load),
    .d       (main_d),
    .valid_d (state_d != SKID_EMPTY),
    .q       (main_q),
    .valid_q (main_valid)
  );

  id_ex_slot #(.W(PW)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_load),
    .d       (in_pay),
    .valid_d (state_d == SKID_FULL),
    .q       (skid_q),
    .valid_q (skid_valid)
  );
`else
  logic main_valid_d;

  assign in_ready = !main_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign rel      = main_valid && out_ready;

  always_comb begin
    main_valid_d = main_valid;
    if (flush)       main_valid_d = 1'b0;
    else if (accept) main_valid_d = 1'b1;
    else if (rel)    main_valid_d = 1'b0;
  end

  id_ex_slot #(.W(PW)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .d       (in_pay),
    .valid_d (main_valid_d),
    .q       (main_q),
    .valid_q (main_valid)
  );
`endif

  assign {ctrl_raw, out_rs1_val, out_rs2_val, out_imm, out_instr,
          out_rs1, out_rs2, out_rd} = main_q;

  // Data fields of a bubble keep their old value; only control is squashed
  // so a bubble can never write the register file or memory.
  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? ctrl_raw : CTRL_W'(ID_EX_CTRL_NOP);

  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!main_valid && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bubble_cnt_q <= '0;
    else        bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage -- self-checking bench for id_ex_stage.
// A scoreboard queue holds every accepted entry; the front is compared with
// the DUT outputs while valid and popped on release. A vector table covers
// streaming and flush, hand sequences cover reset, stall and back-pressure.
// A second instance with CNT_W=4 sits idle to exercise counter saturation.
module tb_id_ex_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [6:0]  in_ctrl, out_ctrl;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm, in_instr;
  logic [31:0] out_rs1_val, out_rs2_val, out_imm, out_instr;
  logic [4:0]  in_rs1, in_rs2, in_rd, out_rs1, out_rs2, out_rd;
  logic [15:0] bubble_cnt;

  logic        c_in_valid, c_in_ready, c_flush, c_out_valid, c_out_ready;
  logic [6:0]  c_in_ctrl, c_out_ctrl;
  logic [31:0] c_in_word, c_out_rs1_val, c_out_rs2_val, c_out_imm, c_out_instr;
  logic [4:0]  c_in_addr, c_out_rs1, c_out_rs2, c_out_rd;
  logic [3:0]  c_bubble_cnt;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_imm(in_imm), .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd(in_rd), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_imm(out_imm), .out_instr(out_instr), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.CNT_W(4)) dut_cnt4 (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_ctrl(c_in_ctrl), .in_rs1_val(c_in_word), .in_rs2_val(c_in_word),
    .in_imm(c_in_word), .in_instr(c_in_word), .in_rs1(c_in_addr),
    .in_rs2(c_in_addr), .in_rd(c_in_addr), .flush(c_flush),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_ctrl(c_out_ctrl),
    .out_rs1_val(c_out_rs1_val), .out_rs2_val(c_out_rs2_val),
    .out_imm(c_out_imm), .out_instr(c_out_instr), .out_rs1(c_out_rs1),
    .out_rs2(c_out_rs2), .out_rd(c_out_rd), .bubble_cnt(c_bubble_cnt)
  );

  typedef struct packed {
    logic [6:0]  ctrl;
    logic [31:0] rs1v, rs2v, imm, instr;
    logic [4:0]  rs1, rs2, rd;
  } txn_t;

  typedef struct {
    logic       v, rdy, fl;
    logic [4:0] rd;
    logic [6:0] ctrl;
    logic       ev;
    logic [4:0] erd;
    logic [6:0] ectrl;
  } vec_t;

  txn_t        sb[$];
  logic [4:0]  rel_log[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] cnt_exp = '0;
  logic [3:0]  cnt4_exp = '0;
  logic        last_fire = 1'b0;
  vec_t        vt[13];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [6:0] ctrl);
    in_valid   = v;
    in_rd      = rd;
    in_ctrl    = ctrl;
    in_rs1_val = $urandom;
    in_rs2_val = $urandom;
    in_imm     = $urandom;
    in_instr   = $urandom;
    in_rs1     = 5'($urandom_range(0, 31));
    in_rs2     = 5'($urandom_range(0, 31));
  endtask

  // One clock: check in_ready against the occupancy model, advance the
  // model across the edge, then compare all outputs 1 time unit later.
  task automatic step();
    logic rdy_exp, fire, rel, fl;
    txn_t cur;
    #1;
`ifdef ID_EX_SKID_EN
    rdy_exp = (sb.size() < 2);
`else
    rdy_exp = (sb.size() == 0) || out_ready;
`endif
    chk("in_ready", in_ready, rdy_exp);
    fl   = flush;
    fire = in_valid && rdy_exp && !fl;
    rel  = (sb.size() != 0) && out_ready;
    cur  = '{in_ctrl, in_rs1_val, in_rs2_val, in_imm, in_instr, in_rs1, in_rs2, in_rd};
    if (sb.size() == 0 && cnt_exp != 16'hFFFF) cnt_exp++;
    if (cnt4_exp != 4'hF) cnt4_exp++;
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete();
    end else begin
      if (rel) begin
        $display("txn released rd=%0d ctrl=%0h", sb[0].rd, sb[0].ctrl);
        rel_log.push_back(sb[0].rd);
        void'(sb.pop_front());
      end
      if (fire) sb.push_back(cur);
    end
    last_fire = fire;
    chk("out_valid", out_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      chk("out_ctrl", out_ctrl, sb[0].ctrl);
      chk("out_rs1_val", out_rs1_val, sb[0].rs1v);
      chk("out_rs2_val", out_rs2_val, sb[0].rs2v);
      chk("out_imm", out_imm, sb[0].imm);
      chk("out_instr", out_instr, sb[0].instr);
      chk("out_rs1", out_rs1, sb[0].rs1);
      chk("out_rs2", out_rs2, sb[0].rs2);
      chk("out_rd", out_rd, sb[0].rd);
    end else begin
      chk("bubble_ctrl", out_ctrl, 7'h00);
    end
    chk("bubble_cnt", bubble_cnt, cnt_exp);
    chk("bubble_cnt4", c_bubble_cnt, cnt4_exp);
  endtask

  // Keep the current input presented until the stage takes it (bounded).
  task automatic hold_until_taken(input string name);
    int n = 0;
    while (in_valid && n < 8) begin
      step();
      if (last_fire) in_valid = 1'b0;
      n++;
    end
    chk(name, in_valid, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 8) begin
      step();
      n++;
    end
    chk("drained", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 7'd0);
    flush = 1'b0;
    out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_ctrl = '0; c_in_word = '0; c_in_addr = '0;
    c_flush = 1'b0; c_out_ready = 1'b1;

    for (int k = 0; k < 8; k++)
      vt[k] = '{1'b1, 1'b1, 1'b0, 5'(k + 1), 7'(65 + k), 1'b1, 5'(k + 1), 7'(65 + k)};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 5'd0,  7'h00, 1'b0, 5'd8,  7'h00};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 5'd10, 7'h1F, 1'b1, 5'd10, 7'h1F};
    vt[10] = '{1'b1, 1'b1, 1'b1, 5'd11, 7'h05, 1'b0, 5'd10, 7'h00};
    vt[11] = '{1'b1, 1'b1, 1'b0, 5'd9,  7'h12, 1'b1, 5'd9,  7'h12};
    vt[12] = '{1'b0, 1'b1, 1'b0, 5'd0,  7'h00, 1'b0, 5'd9,  7'h00};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_ctrl", out_ctrl, 7'h00);
    chk("rst_out_rd", out_rd, 5'd0);
    chk("rst_bubble_cnt", bubble_cnt, 16'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // idle: both counters run, the 4-bit one must stop at 4'hF
    for (int i = 0; i < 20; i++) step();
    chk("cnt4_saturated", c_bubble_cnt, 4'hF);
    chk("cnt_idle20", bubble_cnt, 16'd20);

    // table: streaming rd=1..8 then flush of a ctrl=1F entry
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].v, vt[i].rd, vt[i].ctrl);
      out_ready = vt[i].rdy;
      flush     = vt[i].fl;
      step();
      chk("vec_valid", out_valid, vt[i].ev);
      chk("vec_rd", out_rd, vt[i].erd);
      chk("vec_ctrl", out_ctrl, vt[i].ectrl);
      if (i == 7) chk("stream_cnt_frozen", bubble_cnt, 16'd21);
      if (i == 10) begin
        chk("flush_regwrite", out_ctrl[CTRL_REGWRITE], 1'b0);
        chk("flush_memwrite", out_ctrl[CTRL_MEMWRITE], 1'b0);
        chk("flush_memread", out_ctrl[CTRL_MEMREAD], 1'b0);
        chk("flush_memtoreg", out_ctrl[CTRL_MEMTOREG], 1'b0);
        chk("flush_alusrc", out_ctrl[CTRL_ALUSRC], 1'b0);
        chk("flush_aluop", out_ctrl[CTRL_ALUOP+:2], 2'b00);
      end
    end
    flush = 1'b0;

    // stall: rd=5 held for 3 cycles while EX is not ready
    out_ready = 1'b0;
    drive(1'b1, 5'd5, 7'h15);
    step();
    drive(1'b1, 5'd6, 7'h16);
    for (int i = 0; i < 3; i++) begin
      step();
      if (last_fire) in_valid = 1'b0;
      chk("stall_rd", out_rd, 5'd5);
      chk("stall_ctrl", out_ctrl, 7'h15);
      chk("stall_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    hold_until_taken("stall_rd6_taken");
    drain();

    // back-pressure ordering: rd=3 then rd=4 with EX stalled
    rel_log.delete();
    out_ready = 1'b0;
    drive(1'b1, 5'd3, 7'h13);
    step();
    drive(1'b1, 5'd4, 7'h14);
    step();
    if (last_fire) in_valid = 1'b0;
    chk("full_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    hold_until_taken("rd4_taken");
    drain();
    chk("order_count", rel_log.size(), 2);
    if (rel_log.size() == 2) begin
      chk("order_first", rel_log[0], 5'd3);
      chk("order_second", rel_log[1], 5'd4);
    end

    // asynchronous reset with a valid entry in the stage
    out_ready = 1'b0;
    drive(1'b1, 5'd2, 7'h7F);
    step();
    in_valid = 1'b0;
    chk("pre_reset_ctrl", out_ctrl, 7'h7F);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_ctrl", out_ctrl, 7'h00);
    chk("async_rst_cnt", bubble_cnt, 16'd0);
    chk("async_rst_cnt4", c_bubble_cnt, 4'd0);
    sb.delete();
    cnt_exp  = '0;
    cnt4_exp = '0;
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 5'd9, 7'h11);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 18; i++) step();
    chk("cnt4_no_wrap", c_bubble_cnt, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
